// File: rtl/mem_dump_reader_pkg.sv
// Shared types and default geometry for the test-memory dump reader.
// The reader walks a word range through the memory's test read port.
package mem_dump_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_WORD_W = 32;
    localparam int DEF_DEPTH  = 200;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAP,
        OUT,
        DONE
    } state_e;

endpackage

// File: rtl/mem_dump_reader_if.sv
// Command, memory test-port and output-stream signals of the dump reader.
// master = the reader, slave = the memory/consumer environment around it.
interface mem_dump_reader_if
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = DEF_WORD_W
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] count;

    logic              mem_rwn;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;

    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    logic              busy;
    logic              done;
    logic              err;
    logic [WORD_W-1:0] checksum;

    modport master (
        input  start, base_addr, count, mem_rdata, out_ready,
        output mem_rwn, mem_addr, out_data, out_valid, busy, done, err, checksum
    );

    modport slave (
        output start, base_addr, count, mem_rdata, out_ready,
        input  mem_rwn, mem_addr, out_data, out_valid, busy, done, err, checksum
    );

endinterface

// File: rtl/mem_dump_reader.sv
// Reads base..base+count-1 from the test memory one word at a time, streams each
// word out on valid/ready and keeps an additive checksum of the accepted words.
module mem_dump_reader
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = DEF_WORD_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    mem_dump_reader_if.master bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W-1:0] remaining_q;
    logic [WORD_W-1:0] out_data_q;
    logic [WORD_W-1:0] checksum_q;
    logic              out_valid_q;
    logic              err_q;

    logic [ADDR_W:0]   end_addr;
    logic              range_bad;
    logic              count_zero;
    logic              handshake;
    logic              last_word;
    logic              mem_rwn;
    logic              busy;
    logic              done;

    // One extra bit so base+count cannot wrap past the depth check.
    assign end_addr   = {1'b0, bus.base_addr} + {1'b0, bus.count};
    assign range_bad  = end_addr > (ADDR_W+1)'(DEPTH);
    assign count_zero = (bus.count == '0);
    assign handshake  = out_valid_q && bus.out_ready;
    assign last_word  = (remaining_q == ADDR_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        mem_rwn = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (bus.start && !range_bad) state_d = count_zero ? DONE : REQ;
            end
            REQ: begin
                mem_rwn = 1'b1;
                state_d = CAP;
            end
            CAP:  state_d = OUT;
            OUT:  if (handshake) state_d = last_word ? DONE : REQ;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_addr_q  <= '0;
            last_addr_q <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            checksum_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (range_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q       <= 1'b0;
                            checksum_q  <= '0;
                            cur_addr_q  <= bus.base_addr;
                            remaining_q <= bus.count;
                        end
                    end
                end
                REQ: last_addr_q <= cur_addr_q;
                CAP: begin
                    out_data_q  <= bus.mem_rdata;
                    out_valid_q <= 1'b1;
                end
                OUT: begin
                    if (handshake) begin
                        checksum_q  <= checksum_q + out_data_q;
                        out_valid_q <= 1'b0;
                        remaining_q <= remaining_q - ADDR_W'(1);
                        if (!last_word) cur_addr_q <= cur_addr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Address is live during REQ and otherwise parks on the last one read.
    assign bus.mem_addr  = (state_q == REQ) ? cur_addr_q : last_addr_q;
    assign bus.mem_rwn   = mem_rwn;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.err       = err_q;
    assign bus.checksum  = checksum_q;

endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Read-side initiator for the 200-word test memory. It takes a base address and word count, walks the range through the memory's test read port (`rwn`/`address_test`/`data_out`), and presents each word on a valid/ready output stream. It also accumulates a 32-bit additive checksum of the words delivered. It sits between the memory and the test/verification logic, which consumes dumped contents after the decoder has written them.

## Interface
- `ADDR_W`, 16: memory address width; matches the memory's address ports.
- `WORD_W`, 32: memory word width.
- `DEPTH`, 200: number of valid memory words.

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request a dump; sampled only in IDLE
- `base_addr`  in  ADDR_W  first address; sampled with `start`
- `count`  in  ADDR_W  number of words; sampled with `start`
- `mem_rwn`  out  1  drives memory `rwn`; high exactly in REQ
- `mem_addr`  out  ADDR_W  drives memory `address_test`
- `mem_rdata`  in  WORD_W  memory `data_out`
- `out_data`  out  WORD_W  dumped word
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts the word
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of dump
- `err`  out  1  range error; sticky until the next accepted `start`
- `checksum`  out  WORD_W  running sum mod 2^WORD_W of accepted words

## Operation
- States (package enum): IDLE, REQ, CAP, OUT, DONE.
- IDLE with `start`=1: compute `base_addr + count` at ADDR_W+1 bits.
  - If the sum is greater than `DEPTH`: pulse nothing else, set `err`=1, stay in IDLE.
  - Else if `count`==0: clear `checksum` and `err`, then go to DONE.
  - Else: latch `cur_addr`=`base_addr` and `remaining`=`count`, clear `checksum` and `err`, then go to REQ.
- REQ: `mem_rwn`=1, `mem_addr`=`cur_addr`. The memory registers `data_out` at this edge. Go to CAP.
- CAP: `mem_rdata` is valid. At the edge, load `out_data`, set `out_valid`=1, and go to OUT.
- OUT: hold `out_data`/`out_valid` stable until `out_valid && out_ready` at an edge. On that edge:
  - `checksum` += `out_data` (wraps mod 2^32).
  - `out_valid` goes to 0.
  - `remaining` decrements.
  - If `remaining` was 1, go to DONE. Else `cur_addr`++ and go to REQ.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `checksum` holds until the next accepted `start`.
- `start` outside IDLE is ignored; `base_addr`/`count` changes are ignored after sampling.
- `mem_addr` holds the last driven value outside REQ. `mem_rwn`=0 outside REQ, leaving the memory write port free in every other cycle.

## Timing
- Reset (async assert, `reset`=0): state=IDLE, `mem_rwn`=0, `mem_addr`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `err`=0, `checksum`=0.
- Reset mid-dump aborts immediately. No `done` is produced, and the partial checksum is lost.
- Latency:
  - `start` sampled at edge E0; REQ occupies the cycle after E0.
  - `out_valid` rises after E2.
  - With `out_ready` held high, one word is produced every 3 cycles.
  - `done` is high in the cycle after the last handshake edge.
- `out_ready` may be asserted before `out_valid`; the handshake counts only when both are high at an edge.
- The last legal address is `DEPTH`-1. `base_addr + count` == `DEPTH` is accepted.

## Structure
- `mem_dump_pkg`:
  - state enum
  - `DEPTH`, `ADDR_W`, `WORD_W` defaults
- Single module with an inline address counter, remaining counter and checksum accumulator. No sub-module is needed.

## Test plan
- Preload memory words 10..13 = 0x1, 0x2, 0x3, 0xFFFFFFFF. Start with base=10, count=4, `out_ready`=1.
  - Required: out words 1, 2, 3, 0xFFFFFFFF, each 3 cycles apart.
  - Required: `mem_rwn` high only 4 cycles; `checksum`=0x00000005; single `done` pulse.
- Same dump, with `out_ready` low for 5 cycles on word 2.
  - Required: `out_data`=2 held stable, no extra `mem_rwn`, final `checksum` unchanged.
- base=190, count=11 → `err`=1, `busy` stays 0, `mem_rwn` never asserted. base=190, count=10 → accepted, last address 199.
- count=0 → `done` pulse in the cycle after the sampling edge, `checksum`=0, no reads.
- Assert `reset`=0 while in OUT on word 2.
  - Required: all outputs zero asynchronously. A new start with base=0, count=1 then works normally.
- Pulse `start` during a busy dump with a different base → ignored; the original sequence completes.
